// File: rtl/data_mem_responder_if.sv
// Load/store port between the datapath (master) and the data memory responder (slave).
// Both request and response use valid/ready; a beat transfers on a rising edge where valid && ready.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-array data memory behind a valid/ready load/store port with WAIT_CYCLES wait states.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned addresses return resp_err instead of aligning.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           o_dbg_state
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_in_idle;
  logic             w_acc_write;
  logic [31:0]      w_acc_addr;
  logic [31:0]      w_acc_wdata;
  logic [31:0]      w_offset;
  logic [IDX_W-1:0] w_index;
  logic             w_range_ok;
  logic             w_misalign;
  logic             w_err;
  logic             w_do_access;
  logic             w_mem_we;
  logic [31:0]      w_load_data;
  logic             w_unused_bits;

  // With zero wait states the access happens in the accept cycle, so it must see the live request.
  assign w_in_idle   = (r_state == S_IDLE);
  assign w_acc_write = w_in_idle ? bus.req_write : r_write;
  assign w_acc_addr  = w_in_idle ? bus.req_addr  : r_addr;
  assign w_acc_wdata = w_in_idle ? bus.req_wdata : r_wdata;

  // Modular subtraction makes addresses below BASE_ADDR land far out of range.
  assign w_offset   = w_acc_addr - BASE_ADDR;
  assign w_range_ok = ({2'b00, w_offset[31:2]} < 32'(DEPTH_WORDS));
  assign w_index    = w_offset[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = |w_acc_addr[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_unused_bits = ^w_offset[1:0];
  assign w_err         = ~w_range_ok | w_misalign;

  assign w_do_access = (WAIT_CYCLES == 0) ? (w_in_idle & bus.req_valid)
                                          : ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_mem_we    = w_do_access & w_acc_write & ~w_err;
  assign w_load_data = (w_acc_write | w_err) ? 32'h0 : r_mem[w_index];

  // Storage has no reset: contents survive reset_n, and an aborted store never reaches here.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_index] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'h0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_write     <= bus.req_write;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_rdata      <= w_load_data;
              r_err        <= w_err;
              r_resp_valid <= 1'b1;
              r_cnt        <= 4'd0;
              r_state      <= S_RESP;
            end else begin
              r_cnt   <= 4'(WAIT_CYCLES);
              r_state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (w_do_access) begin
            r_rdata      <= w_load_data;
            r_err        <= w_err;
            r_resp_valid <= 1'b1;
            r_cnt        <= 4'd0;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_RESP: begin
          // Handshake cycle only retires the response; the next request waits for IDLE.
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_cnt        <= 4'd0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
// Expectations for misaligned accesses follow DMEM_ALIGN_CHECK_EN.
module tb_data_mem_responder;

  localparam logic [1:0] ST_IDLE = 2'd0;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg2;
  logic [1:0] dbg0;
  int         n_checks = 0;
  int         n_err = 0;

  always #5 clock = ~clock;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut2 (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus2),
    .o_dbg_state (dbg2)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus0),
    .o_dbg_state (dbg0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic rv(input bit sel);
    return sel ? bus0.resp_valid : bus2.resp_valid;
  endfunction

  function automatic logic rr(input bit sel);
    return sel ? bus0.req_ready : bus2.req_ready;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input bit sel, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input string tag);
    if (sel) begin
      bus0.req_write = wr; bus0.req_addr = addr; bus0.req_wdata = wd; bus0.req_valid = 1'b1;
    end else begin
      bus2.req_write = wr; bus2.req_addr = addr; bus2.req_wdata = wd; bus2.req_valid = 1'b1;
    end
    chk({tag, "_req_ready"}, 32'(rr(sel)), 32'd1);
    @(negedge clock);
    if (sel) bus0.req_valid = 1'b0; else bus2.req_valid = 1'b0;
  endtask

  // Latency counts the accept cycle as cycle 1.
  task automatic wait_resp(input bit sel, input int exp_lat, input string tag);
    int n = 1;
    while (!rv(sel) && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic take(input bit sel, input logic [31:0] exp_rd, input logic exp_e, input string tag);
    chk({tag, "_rdata"}, sel ? bus0.resp_rdata : bus2.resp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(sel ? bus0.resp_err : bus2.resp_err), 32'(exp_e));
    chk({tag, "_busy"}, 32'(rr(sel)), 32'd0);
    if (sel) bus0.resp_ready = 1'b1; else bus2.resp_ready = 1'b1;
    @(negedge clock);
    if (sel) bus0.resp_ready = 1'b0; else bus2.resp_ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(rv(sel)), 32'd0);
    chk({tag, "_ready_back"}, 32'(rr(sel)), 32'd1);
  endtask

  task automatic xfer(input bit sel, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int lat, input logic [31:0] exp_rd, input logic exp_e, input string tag);
    send(sel, wr, addr, wd, tag);
    wait_resp(sel, lat, tag);
    take(sel, exp_rd, exp_e, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] exp_misal_rd;
    logic        exp_misal_err;
    logic [31:0] exp_w20;

    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = 32'h0; bus2.req_wdata = 32'h0;
    bus2.resp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
    bus0.resp_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(bus2.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
    chk("rst_rdata", bus2.resp_rdata, 32'h0);
    chk("rst_err", 32'(bus2.resp_err), 32'd0);
    chk("rst_state", 32'(dbg2), 32'(ST_IDLE));
    chk("rst0_resp_valid", 32'(bus0.resp_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Store then load with two wait states
    xfer(0, 1, 32'h10, 32'hDEAD_BEEF, 3, 32'h0, 1'b0, "st10");
    xfer(0, 0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, "ld10");

    // Back-pressure: response held, and request traffic during RESP is ignored
    send(0, 0, 32'h10, 32'h0, "hold");
    wait_resp(0, 3, "hold");
    bus2.req_valid = 1'b1; bus2.req_write = 1'b1; bus2.req_addr = 32'h10;
    bus2.req_wdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_valid", 32'(bus2.resp_valid), 32'd1);
      chk("hold_rdata", bus2.resp_rdata, 32'hDEAD_BEEF);
      chk("hold_req_ready", 32'(bus2.req_ready), 32'd0);
    end
    bus2.resp_ready = 1'b1;
    @(negedge clock);
    bus2.resp_ready = 1'b0;
    chk("hs_valid_clr", 32'(bus2.resp_valid), 32'd0);
    chk("hs_no_accept", 32'(dbg2), 32'(ST_IDLE));
    bus2.req_valid = 1'b0;
    @(negedge clock);
    chk("hs_still_idle", 32'(dbg2), 32'(ST_IDLE));
    xfer(0, 0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, "ld10_after_hold");

    // Range boundaries: last word, one past the end, below base
    xfer(0, 1, 32'h0, 32'h0000_AAAA, 3, 32'h0, 1'b0, "st0");
    xfer(0, 1, 32'h3FC, 32'hBBBB_0001, 3, 32'h0, 1'b0, "st3fc");
    xfer(0, 0, 32'h3FC, 32'h0, 3, 32'hBBBB_0001, 1'b0, "ld3fc");
    xfer(0, 0, 32'h400, 32'h0, 3, 32'h0, 1'b1, "ld400");
    xfer(0, 1, 32'h400, 32'hCAFE_F00D, 3, 32'h0, 1'b1, "st400");
    xfer(0, 0, 32'h0, 32'h0, 3, 32'h0000_AAAA, 1'b0, "ld0_no_alias");
    xfer(0, 0, 32'hFFFF_FFFC, 32'h0, 3, 32'h0, 1'b1, "ld_below_base");

    // Zero wait states, back to back
    xfer(1, 1, 32'h0, 32'h1234_5678, 1, 32'h0, 1'b0, "w0_st0");
    xfer(1, 0, 32'h0, 32'h0, 1, 32'h1234_5678, 1'b0, "w0_ld0");

    // Reset during WAIT of a store aborts it
    xfer(0, 1, 32'h20, 32'h55AA_55AA, 3, 32'h0, 1'b0, "st20_old");
    send(0, 1, 32'h20, 32'h9999_9999, "st20_abort");
    reset_n = 1'b0;
    #1;
    chk("abort_resp_valid", 32'(bus2.resp_valid), 32'd0);
    chk("abort_req_ready", 32'(bus2.req_ready), 32'd1);
    chk("abort_state", 32'(dbg2), 32'(ST_IDLE));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    xfer(0, 0, 32'h20, 32'h0, 3, 32'h55AA_55AA, 1'b0, "ld20_old");

    // Misaligned accesses
`ifdef DMEM_ALIGN_CHECK_EN
    exp_misal_rd = 32'h0; exp_misal_err = 1'b1; exp_w20 = 32'h55AA_55AA;
`else
    exp_misal_rd = 32'hDEAD_BEEF; exp_misal_err = 1'b0; exp_w20 = 32'h7777_7777;
`endif
    xfer(0, 0, 32'h13, 32'h0, 3, exp_misal_rd, exp_misal_err, "ld13");
    xfer(0, 1, 32'h22, 32'h7777_7777, 3, 32'h0, exp_misal_err, "st22");
    xfer(0, 0, 32'h20, 32'h0, 3, exp_w20, 1'b0, "ld20_after_st22");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
